opb_initiator_simulink: RTL and testbench

OPB_INITIATOR_SIMULINK -- requirements
Module: opb_initiator_simulink

---
 rtl/opb_pkg.sv | 22 ++
 rtl/opb_initiator_simulink.sv | 172 +++++++++++++++++
 tb/tb_opb_initiator_simulink.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_pkg.sv
//==============================================================================
// Module   : opb_pkg
// Brief    : Shared OPB width constants and initiator FSM state encodings.
// Revision : 1.0
//==============================================================================
`default_nettype none

package opb_pkg;

  localparam int C_OPB_AWIDTH_DEF = 32;
  localparam int C_OPB_DWIDTH_DEF = 32;

  typedef logic [1:0] opb_state_t;

  localparam opb_state_t C_ST_IDLE = 2'd0;
  localparam opb_state_t C_ST_REQ  = 2'd1;
  localparam opb_state_t C_ST_XFER = 2'd2;
  localparam opb_state_t C_ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/opb_initiator_simulink.sv
//==============================================================================
// Module   : opb_initiator_simulink
// Brief    : Single-beat OPB master with retry limit; optional XFER watchdog
//            enabled by defining OPB_INITIATOR_WATCHDOG_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module opb_initiator_simulink
  import opb_pkg::*;
#(
  parameter int    C_OPB_AWIDTH  = C_OPB_AWIDTH_DEF,
  parameter int    C_OPB_DWIDTH  = C_OPB_DWIDTH_DEF,
  parameter int    C_MAX_RETRIES = 7,
  parameter int    C_WDOG_CYCLES = 16,
  parameter string C_FAMILY      = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic                      user_req,
  input  logic                      user_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   user_addr,
  input  logic [C_OPB_DWIDTH-1:0]   user_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0] user_be,
  output logic                      user_ready,
  output logic                      user_done,
  output logic [C_OPB_DWIDTH-1:0]   user_rdata,
  output logic                      user_err,
  output logic                      M_request,
  output logic                      M_busLock,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic                      M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  input  logic                      OPB_MGrant,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

  localparam int RW = (C_MAX_RETRIES < 1) ? 1 : $clog2(C_MAX_RETRIES + 1);

  // Configuration sanity guard; an empty family or zero watchdog limit is meaningless.
  if (C_FAMILY == "" || C_WDOG_CYCLES < 1) begin : g_cfg_invalid
  end

  opb_state_t                r_state;
  opb_state_t                w_next;
  logic                      r_rnw;
  logic [C_OPB_AWIDTH-1:0]   r_addr;
  logic [C_OPB_DWIDTH-1:0]   r_wdata;
  logic [C_OPB_DWIDTH/8-1:0] r_be;
  logic [RW-1:0]             r_retry;
  logic [C_OPB_DWIDTH-1:0]   r_rdata;
  logic                      r_err;

  logic w_in_xfer;
  logic w_err_evt;
  logic w_ack_evt;
  logic w_rty_evt;
  logic w_rty_exhaust;
  logic w_wdog_evt;

  // Slave event priority: errAck/timeout, then xferAck, then retry.
  assign w_in_xfer     = (r_state == C_ST_XFER);
  assign w_err_evt     = w_in_xfer & (OPB_errAck | OPB_timeout);
  assign w_ack_evt     = w_in_xfer & ~w_err_evt & OPB_xferAck;
  assign w_rty_evt     = w_in_xfer & ~w_err_evt & ~OPB_xferAck & OPB_retry;
  assign w_rty_exhaust = w_rty_evt & (r_retry == RW'(C_MAX_RETRIES));

`ifdef OPB_INITIATOR_WATCHDOG_EN
  localparam int WW = (C_WDOG_CYCLES < 1) ? 1 : $clog2(C_WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog;

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n || !w_in_xfer) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WW'(1);
    end
  end

  assign w_wdog_evt = w_in_xfer & ~w_err_evt & ~OPB_xferAck & ~OPB_retry &
                      (r_wdog == WW'(C_WDOG_CYCLES - 1));
`else
  assign w_wdog_evt = 1'b0;
`endif

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_ST_IDLE: if (user_req) w_next = C_ST_REQ;
      C_ST_REQ:  if (OPB_MGrant) w_next = C_ST_XFER;
      C_ST_XFER: begin
        if (w_err_evt || w_ack_evt || w_rty_exhaust || w_wdog_evt) begin
          w_next = C_ST_DONE;
        end else if (w_rty_evt) begin
          w_next = C_ST_REQ;
        end
      end
      default:   w_next = C_ST_IDLE;
    endcase
  end

  // Bus outputs stay all-zero outside XFER so they can be OR-combined on the OPB.
  always_comb begin
    user_ready = (r_state == C_ST_IDLE);
    user_done  = (r_state == C_ST_DONE);
    M_request  = (r_state == C_ST_REQ);
    M_select   = w_in_xfer;
    M_busLock  = 1'b0;
    M_seqAddr  = 1'b0;
    M_RNW      = 1'b0;
    M_ABus     = '0;
    M_BE       = '0;
    M_DBus     = '0;
    if (w_in_xfer) begin
      M_RNW  = r_rnw;
      M_ABus = r_addr;
      M_BE   = r_be;
      if (!r_rnw) M_DBus = r_wdata;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_retry <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == C_ST_IDLE && user_req) begin
        r_rnw   <= user_rnw;
        r_addr  <= user_addr;
        r_wdata <= user_wdata;
        r_be    <= user_be;
        r_retry <= '0;
      end
      if (w_ack_evt) begin
        r_err <= 1'b0;
        if (r_rnw) r_rdata <= OPB_DBus;
      end
      if (w_err_evt || w_rty_exhaust || w_wdog_evt) begin
        r_err <= 1'b1;
      end
      if (w_rty_evt && !w_rty_exhaust) begin
        r_retry <= r_retry + RW'(1);
      end
    end
  end

  assign user_rdata = r_rdata;
  assign user_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_opb_initiator_simulink.sv
//==============================================================================
// Module   : tb_opb_initiator_simulink
// Brief    : Self-checking bench for opb_initiator_simulink with a
//            transaction-level slave-response model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_opb_initiator_simulink;

  localparam int MAXR   = 7;
  localparam int WDOG   = 16;
  localparam int BUDGET = 300;

  logic        OPB_Clk     = 1'b0;
  logic        OPB_Rst_n   = 1'b0;
  logic        user_req    = 1'b0;
  logic        user_rnw    = 1'b0;
  logic [31:0] user_addr   = '0;
  logic [31:0] user_wdata  = '0;
  logic [3:0]  user_be     = '0;
  logic        user_ready, user_done, user_err;
  logic [31:0] user_rdata;
  logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant  = 1'b0;
  logic        OPB_xferAck = 1'b0;
  logic        OPB_errAck  = 1'b0;
  logic        OPB_retry   = 1'b0;
  logic        OPB_timeout = 1'b0;
  logic [0:31] OPB_DBus    = '0;

  int checks = 0;
  int errors = 0;

  // Slave response script, one entry per XFER cycle: {timeout, errAck, xferAck, retry}
  logic [3:0]  rq[$];
  logic [31:0] dq[$];
  logic [31:0] exp_rdata = '0;
  int          last_lat  = 0;
  int          last_nreq = 0;

  opb_initiator_simulink dut (
    .OPB_Clk    (OPB_Clk),
    .OPB_Rst_n  (OPB_Rst_n),
    .user_req   (user_req),
    .user_rnw   (user_rnw),
    .user_addr  (user_addr),
    .user_wdata (user_wdata),
    .user_be    (user_be),
    .user_ready (user_ready),
    .user_done  (user_done),
    .user_rdata (user_rdata),
    .user_err   (user_err),
    .M_request  (M_request),
    .M_busLock  (M_busLock),
    .M_select   (M_select),
    .M_RNW      (M_RNW),
    .M_seqAddr  (M_seqAddr),
    .M_ABus     (M_ABus),
    .M_BE       (M_BE),
    .M_DBus     (M_DBus),
    .OPB_MGrant (OPB_MGrant),
    .OPB_xferAck(OPB_xferAck),
    .OPB_errAck (OPB_errAck),
    .OPB_retry  (OPB_retry),
    .OPB_timeout(OPB_timeout),
    .OPB_DBus   (OPB_DBus)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic rnw, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int gdelay);
    int          k = 0, ph_cnt = 0, nreq = 0, held = 0, xi = 0, bus_bad = 0;
    int          retries = 0, wd = 0, m_ph = 1, m_x = 0;
    logic        fin = 1'b0, m_err = 1'b0;
    logic [31:0] m_rd;
    logic [3:0]  r;

    // Reference: walk the response script by the priority rules until the transfer ends.
    while (dq.size() < rq.size()) dq.push_back($urandom);
    m_rd = exp_rdata;
    for (int i = 0; !fin; i++) begin
      if (i == rq.size()) begin
        rq.push_back(4'b0010);
        dq.push_back($urandom);
      end
      r = rq[i];
      m_x++;
      wd++;
      if (r[3] || r[2]) begin
        m_err = 1'b1; fin = 1'b1;
      end else if (r[1]) begin
        m_err = 1'b0; fin = 1'b1;
        if (rnw) m_rd = dq[i];
      end else if (r[0]) begin
        if (retries == MAXR) begin
          m_err = 1'b1; fin = 1'b1;
        end else begin
          retries++; m_ph++; wd = 0;
        end
      end
`ifdef OPB_INITIATOR_WATCHDOG_EN
      else if (wd == WDOG) begin
        m_err = 1'b1; fin = 1'b1;
      end
`endif
    end

    @(negedge OPB_Clk);
    chk({tag, ":ready"}, 32'(user_ready), 32'd1);
    user_req = 1'b1; user_rnw = rnw; user_addr = addr; user_wdata = wdata; user_be = be;
    @(posedge OPB_Clk);
    while (k < BUDGET) begin
      @(negedge OPB_Clk);
      k++;
      user_req   = 1'($urandom_range(0, 1));
      user_rnw   = 1'($urandom_range(0, 1));
      user_addr  = $urandom;
      user_wdata = $urandom;
      user_be    = 4'($urandom_range(0, 15));
      OPB_MGrant = 1'b0;
      {OPB_timeout, OPB_errAck, OPB_xferAck, OPB_retry} = 4'b0000;
      OPB_DBus   = $urandom;
      if (user_done) break;
      if (user_ready) bus_bad++;
      if (M_request) begin
        if (M_select || M_ABus != 0 || M_DBus != 0 || M_BE != 0 || M_RNW) bus_bad++;
        if (ph_cnt == 0) nreq++;
        if (ph_cnt >= gdelay) begin
          OPB_MGrant = 1'b1;
          ph_cnt = 0;
        end else begin
          ph_cnt++;
          held++;
        end
      end else if (M_select) begin
        if (M_ABus !== addr || M_BE !== be || M_RNW !== rnw ||
            M_DBus !== (rnw ? 32'd0 : wdata)) bus_bad++;
        if (xi < rq.size()) begin
          {OPB_timeout, OPB_errAck, OPB_xferAck, OPB_retry} = rq[xi];
          OPB_DBus = dq[xi];
        end
        xi++;
      end else begin
        bus_bad++;
      end
    end
    user_req = 1'b0;
    chk({tag, ":done"},  32'(user_done), 32'd1);
    chk({tag, ":err"},   32'(user_err), 32'(m_err));
    chk({tag, ":rdata"}, user_rdata, m_rd);
    chk({tag, ":nreq"},  32'(nreq), 32'(m_ph));
    chk({tag, ":held"},  32'(held), 32'(m_ph * gdelay));
    chk({tag, ":lat"},   32'(k), 32'(m_ph * (gdelay + 1) + m_x + 1));
    chk({tag, ":bus"},   32'(bus_bad), 32'd0);
    exp_rdata = m_rd;
    last_lat  = k;
    last_nreq = nreq;
    @(negedge OPB_Clk);
    chk({tag, ":pulse"}, {30'd0, user_done, user_ready}, 32'd1);
    rq.delete();
    dq.delete();
  endtask

  initial begin
    int nd;
    logic rnw;

    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("rst:ready", 32'(user_ready), 32'd1);
    chk("rst:done",  32'(user_done), 32'd0);
    chk("rst:err",   32'(user_err), 32'd0);
    chk("rst:rdata", user_rdata, 32'd0);
    chk("rst:mctl",  {27'd0, M_request, M_busLock, M_select, M_RNW, M_seqAddr}, 32'd0);
    chk("rst:mbus",  M_ABus | M_DBus | {28'd0, M_BE}, 32'd0);
    OPB_Rst_n = 1'b1;

    xfer("wr_imm", 1'b0, 32'h0100_4500, 32'hDEAD_BEEF, 4'hF, 0);
    chk("wr_imm:lat3", 32'(last_lat), 32'd3);

    rq.push_back(4'b0010);
    dq.push_back(32'h1234_5678);
    xfer("rd_imm", 1'b1, 32'h0000_0040, 32'h0, 4'hF, 0);
    chk("rd_imm:val", user_rdata, 32'h1234_5678);

    xfer("gnt_wait", 1'b0, 32'h0000_1000, 32'hA5A5_5A5A, 4'h3, 5);

    repeat (8) rq.push_back(4'b0001);
    xfer("retry8", 1'b1, 32'h0000_2000, 32'h0, 4'hF, 0);
    chk("retry8:rereq", 32'(last_nreq - 1), 32'd7);

    rq.push_back(4'b0110);
    xfer("err_ack", 1'b1, 32'h0000_3000, 32'h0, 4'hF, 0);

    rq.push_back(4'b1001);
    xfer("tmo_rty", 1'b0, 32'h0000_3004, 32'h1111_2222, 4'hC, 1);

    repeat (20) rq.push_back(4'b0000);
    xfer("wdog", 1'b1, 32'h0000_4000, 32'h0, 4'hF, 0);

    for (int n = 0; n < 20; n++) begin
      rnw = 1'($urandom_range(0, 1));
      for (int j = 0; j < $urandom_range(0, 3); j++) rq.push_back(4'($urandom_range(0, 15)));
      xfer("rand", rnw, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Reset while the transfer is in XFER.
    @(negedge OPB_Clk);
    user_req = 1'b1; user_rnw = 1'b0; user_addr = 32'h0000_5000; user_wdata = 32'hCAFE_F00D;
    @(negedge OPB_Clk);
    user_req = 1'b0;
    OPB_MGrant = 1'b1;
    @(negedge OPB_Clk);
    OPB_MGrant = 1'b0;
    chk("rstx:pre_sel", 32'(M_select), 32'd1);
    OPB_Rst_n = 1'b0;
    @(posedge OPB_Clk);
    #1;
    chk("rstx:sel",   32'(M_select), 32'd0);
    chk("rstx:req",   32'(M_request), 32'd0);
    chk("rstx:done",  32'(user_done), 32'd0);
    chk("rstx:rdata", user_rdata, 32'd0);
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge OPB_Clk);
      if (user_done) nd++;
    end
    chk("rstx:nodone", 32'(nd), 32'd0);
    chk("rstx:ready",  32'(user_ready), 32'd1);
    exp_rdata = '0;

    rq.push_back(4'b0010);
    xfer("post_rst", 1'b1, 32'h0000_6000, 32'h0, 4'h1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
